audio_mixer: RTL and testbench



---
 rtl/audio_mixer_if.sv | 34 +++
 rtl/audio_mixer.sv | 140 ++++++++++++++
 tb/tb_audio_mixer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_if.sv
`timescale 1ns/1ps
// Bundle between the sound sources / register block and audio_mixer.
// The mixer takes the slave side; the source side drives samples and strobes.
interface audio_mixer_if #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 24,
  parameter int VOL_W  = 4
);
  logic                     next_sample;
  logic [NUM_CH*IN_W-1:0]   ch_left;
  logic [NUM_CH*IN_W-1:0]   ch_right;
  logic [NUM_CH*VOL_W-1:0]  ch_vol;
  logic [NUM_CH-1:0]        ch_mute;
  logic [VOL_W-1:0]         master_vol;
  logic                     clip_clear;
  logic [OUT_W-1:0]         out_left;
  logic [OUT_W-1:0]         out_right;
  logic                     out_valid;
  logic                     busy;
  logic                     clip_left;
  logic                     clip_right;
  logic                     overrun;

  modport master (
    output next_sample, ch_left, ch_right, ch_vol, ch_mute, master_vol, clip_clear,
    input  out_left, out_right, out_valid, busy, clip_left, clip_right, overrun
  );

  modport slave (
    input  next_sample, ch_left, ch_right, ch_vol, ch_mute, master_vol, clip_clear,
    output out_left, out_right, out_valid, busy, clip_left, clip_right, overrun
  );
endinterface

// File: rtl/audio_mixer.sv
`timescale 1ns/1ps
// Time-multiplexed stereo mixer: snapshot NUM_CH channels, accumulate one channel
// per clock, apply master volume, saturate and emit a left-aligned sample pair.
module audio_mixer #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 24,
  parameter int VOL_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  audio_mixer_if.slave    bus
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = IN_W + VOL_W + 1;
  localparam int ACC_W  = IN_W + VOL_W + $clog2(NUM_CH) + 1;
  localparam int MIX_W  = ACC_W + VOL_W + 1;
  localparam int SHIFT  = 2 * (VOL_W - 1);
  localparam int PAD    = OUT_W - IN_W - 1;

  localparam logic signed [MIX_W-1:0] SAT_MAX = MIX_W'((1 <<< IN_W) - 1);
  localparam logic signed [MIX_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, MASTER, OUTPUT} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic signed [IN_W-1:0]  snap_l [NUM_CH];
  logic signed [IN_W-1:0]  snap_r [NUM_CH];
  logic [VOL_W-1:0]        snap_vol [NUM_CH];
  logic [NUM_CH-1:0]       snap_mute;
  logic [VOL_W-1:0]        snap_master;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [MIX_W-1:0] mix_l, mix_r;

  logic signed [PROD_W-1:0] prod_l, prod_r;
  logic signed [MIX_W-1:0]  mix_next_l, mix_next_r;
  logic signed [IN_W:0]     sat_l, sat_r;
  logic                     clip_now_l, clip_now_r;

  function automatic logic [IN_W+1:0] saturate(input logic signed [MIX_W-1:0] m);
    if (m > SAT_MAX)      return {1'b1, SAT_MAX[IN_W:0]};
    else if (m < SAT_MIN) return {1'b1, SAT_MIN[IN_W:0]};
    return {1'b0, m[IN_W:0]};
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    prod_l = '0;
    prod_r = '0;
    if (!snap_mute[idx]) begin
      // Volume codes are unsigned: zero-extend before the signed multiply.
      prod_l = PROD_W'(snap_l[idx]) * PROD_W'($signed({1'b0, snap_vol[idx]}));
      prod_r = PROD_W'(snap_r[idx]) * PROD_W'($signed({1'b0, snap_vol[idx]}));
    end
  end

  always_comb begin
    mix_next_l = (MIX_W'(acc_l) * MIX_W'($signed({1'b0, snap_master}))) >>> SHIFT;
    mix_next_r = (MIX_W'(acc_r) * MIX_W'($signed({1'b0, snap_master}))) >>> SHIFT;
    {clip_now_l, sat_l} = saturate(mix_l);
    {clip_now_r, sat_r} = saturate(mix_r);
  end

  assign bus.busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      acc_l          <= '0;
      acc_r          <= '0;
      mix_l          <= '0;
      mix_r          <= '0;
      snap_mute      <= '0;
      snap_master    <= '0;
      // NOTE: the snapshot registers are reset too, so a mix after reset never sees stale data.
      for (int i = 0; i < NUM_CH; i++) begin
        snap_l[i]   <= '0;
        snap_r[i]   <= '0;
        snap_vol[i] <= '0;
      end
      bus.out_left   <= '0;
      bus.out_right  <= '0;
      bus.out_valid  <= 1'b0;
      bus.clip_left  <= 1'b0;
      bus.clip_right <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.clip_clear) begin
        bus.clip_left  <= 1'b0;
        bus.clip_right <= 1'b0;
        bus.overrun    <= 1'b0;
      end
      if (bus.next_sample && state != IDLE) bus.overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.next_sample) begin
            for (int i = 0; i < NUM_CH; i++) begin
              snap_l[i]   <= bus.ch_left[i*IN_W +: IN_W];
              snap_r[i]   <= bus.ch_right[i*IN_W +: IN_W];
              snap_vol[i] <= bus.ch_vol[i*VOL_W +: VOL_W];
            end
            snap_mute   <= bus.ch_mute;
            snap_master <= bus.master_vol;
            acc_l       <= '0;
            acc_r       <= '0;
            idx         <= '0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          acc_l <= acc_l + ACC_W'(prod_l);
          acc_r <= acc_r + ACC_W'(prod_r);
          if (idx == IDX_W'(NUM_CH - 1)) state <= MASTER;
          else                           idx   <= idx + 1'b1;
        end
        MASTER: begin
          mix_l <= mix_next_l;
          mix_r <= mix_next_r;
          state <= OUTPUT;
        end
        OUTPUT: begin
          bus.out_left  <= OUT_W'(sat_l) << PAD;
          bus.out_right <= OUT_W'(sat_r) << PAD;
          bus.out_valid <= 1'b1;
          if (clip_now_l) bus.clip_left  <= 1'b1;
          if (clip_now_r) bus.clip_right <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
`timescale 1ns/1ps
// Self-checking bench for audio_mixer: an arithmetic reference model with a
// countdown timeline, checked every cycle, plus directed literal scenarios.
module tb_audio_mixer;
  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 24;
  localparam int VOL_W  = 4;
  localparam int LAT    = NUM_CH + 2;
  localparam longint UNITY = 1 << (VOL_W - 1);
  localparam longint S_MAX = (64'sd1 <<< IN_W) - 1;
  localparam longint S_MIN = -(64'sd1 <<< IN_W);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  audio_mixer_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .VOL_W(VOL_W)) mix_if ();

  audio_mixer #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .VOL_W(VOL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mix_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference mix of one side: returns {clip, left-aligned sample}.
  function automatic logic [OUT_W:0] mix_one(input logic [NUM_CH*IN_W-1:0] s,
                                             input logic [NUM_CH*VOL_W-1:0] v,
                                             input logic [NUM_CH-1:0] mu,
                                             input logic [VOL_W-1:0] mv);
    longint sum, m, q, o;
    logic clip;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (!mu[i]) sum += longint'($signed(s[i*IN_W +: IN_W])) * longint'(v[i*VOL_W +: VOL_W]);
    m = sum * longint'(mv);
    q = m / (UNITY * UNITY);
    if (m < 0 && (m % (UNITY * UNITY)) != 0) q = q - 1;
    clip = 1'b0;
    if (q > S_MAX) begin q = S_MAX; clip = 1'b1; end
    if (q < S_MIN) begin q = S_MIN; clip = 1'b1; end
    o = q * (64'sd1 <<< (OUT_W - IN_W - 1));
    return {clip, o[OUT_W-1:0]};
  endfunction

  // Expected-state model, advanced on the same edges the DUT samples.
  int               cnt;
  logic [OUT_W-1:0] exp_l, exp_r, pend_l, pend_r;
  logic             pend_cl, pend_cr;
  logic             exp_valid, exp_busy, exp_clip_l, exp_clip_r, exp_ovr;

  initial begin
    cnt = 0; exp_l = '0; exp_r = '0; pend_l = '0; pend_r = '0; pend_cl = 0; pend_cr = 0;
    exp_valid = 0; exp_busy = 0; exp_clip_l = 0; exp_clip_r = 0; exp_ovr = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cnt = 0; exp_l = '0; exp_r = '0;
        exp_valid = 0; exp_busy = 0; exp_clip_l = 0; exp_clip_r = 0; exp_ovr = 0;
      end else begin
        exp_valid = 0;
        if (mix_if.clip_clear) begin exp_clip_l = 0; exp_clip_r = 0; exp_ovr = 0; end
        if (cnt > 0) begin
          if (mix_if.next_sample) exp_ovr = 1;
          cnt--;
          if (cnt == 0) begin
            exp_valid = 1;
            exp_l = pend_l;
            exp_r = pend_r;
            if (pend_cl) exp_clip_l = 1;
            if (pend_cr) exp_clip_r = 1;
          end
        end else if (mix_if.next_sample) begin
          cnt = LAT;
          {pend_cl, pend_l} = mix_one(mix_if.ch_left,  mix_if.ch_vol, mix_if.ch_mute, mix_if.master_vol);
          {pend_cr, pend_r} = mix_one(mix_if.ch_right, mix_if.ch_vol, mix_if.ch_mute, mix_if.master_vol);
        end
        exp_busy = (cnt > 0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      check("out_left",   mix_if.out_left,   exp_l);
      check("out_right",  mix_if.out_right,  exp_r);
      check("out_valid",  mix_if.out_valid,  exp_valid);
      check("busy",       mix_if.busy,       exp_busy);
      check("clip_left",  mix_if.clip_left,  exp_clip_l);
      check("clip_right", mix_if.clip_right, exp_clip_r);
      check("overrun",    mix_if.overrun,    exp_ovr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_chan(input int i, input int l, input int r, input int v, input bit m);
    mix_if.ch_left[i*IN_W +: IN_W]   = IN_W'(l);
    mix_if.ch_right[i*IN_W +: IN_W]  = IN_W'(r);
    mix_if.ch_vol[i*VOL_W +: VOL_W]  = VOL_W'(v);
    mix_if.ch_mute[i]                = m;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NUM_CH; i++) set_chan(i, 0, 0, 8, 1'b0);
    mix_if.master_vol = VOL_W'(8);
  endtask

  task automatic fire();
    mix_if.next_sample = 1'b1;
    tick();
    mix_if.next_sample = 1'b0;
  endtask

  task automatic pulse_clear();
    mix_if.clip_clear = 1'b1;
    tick();
    mix_if.clip_clear = 1'b0;
  endtask

  // Strobe, then watch a bounded window; latency counted in edges after the strobe edge.
  task automatic run_mix(output int lat, output int nv);
    fire();
    lat = -1;
    nv  = 0;
    for (int i = 1; i <= LAT + 6; i++) begin
      tick();
      if (mix_if.out_valid) begin
        nv++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  int lat, nv;
  logic [OUT_W:0] pin;

  initial begin
    mix_if.next_sample = 1'b0;
    mix_if.clip_clear  = 1'b0;
    clear_inputs();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("reset_out_left", mix_if.out_left, 0);
    check("reset_busy", mix_if.busy, 0);
    check("reset_flags", {mix_if.clip_left, mix_if.clip_right, mix_if.overrun}, 0);

    pin = mix_one(64'h0000_0000_0000_03E8, 16'h8888, 4'b0000, 4'd8);
    check("model_unity", pin, {1'b0, 24'h01F400});
    pin = mix_one(64'h7FFF_7FFF_7FFF_7FFF, 16'hFFFF, 4'b0000, 4'd15);
    check("model_pos_sat", pin, {1'b1, 24'h7FFF80});
    pin = mix_one(64'h8000_8000_8000_8000, 16'h8888, 4'b0000, 4'd8);
    check("model_neg_sat", pin, {1'b1, 24'h800000});
    pin = mix_one(64'h0000_0000_0FA0_0FA0, 16'h8884, 4'b0010, 4'd8);
    check("model_mute_vol", pin, {1'b0, 24'h03E800});
    pin = mix_one(64'h0000_0000_0000_FFFF, 16'h0001, 4'b0000, 4'd1);
    check("model_floor", pin, {1'b0, 24'hFFFF80});

    // Unity passthrough
    set_chan(0, 1000, -1000, 8, 1'b0);
    run_mix(lat, nv);
    check("unity_latency", lat, LAT);
    check("unity_valid_count", nv, 1);
    check("unity_left", mix_if.out_left, 24'h01F400);
    check("unity_right", mix_if.out_right, 24'hFE0C00);
    check("unity_clip", {mix_if.clip_left, mix_if.clip_right}, 0);

    // Positive saturation
    for (int i = 0; i < NUM_CH; i++) set_chan(i, 32'h7FFF, 0, 15, 1'b0);
    mix_if.master_vol = 4'd15;
    run_mix(lat, nv);
    check("pos_sat_left", mix_if.out_left, 24'h7FFF80);
    check("pos_sat_right", mix_if.out_right, 0);
    check("pos_sat_clip", {mix_if.clip_left, mix_if.clip_right}, 2'b10);

    pulse_clear();
    check("clip_cleared", mix_if.clip_left, 0);

    // Negative saturation
    for (int i = 0; i < NUM_CH; i++) set_chan(i, -32768, 0, 8, 1'b0);
    mix_if.master_vol = 4'd8;
    run_mix(lat, nv);
    check("neg_sat_left", mix_if.out_left, 24'h800000);
    check("neg_sat_clip", mix_if.clip_left, 1);
    pulse_clear();
    check("neg_clip_cleared", mix_if.clip_left, 0);
    fire();
    tick(LAT - 1);
    mix_if.clip_clear = 1'b1;
    tick();
    mix_if.clip_clear = 1'b0;
    check("set_wins_valid", mix_if.out_valid, 1);
    check("set_wins_clip", mix_if.clip_left, 1);

    // Mute and volume; inputs altered during ACCUM must not matter
    clear_inputs();
    set_chan(0, 4000, 0, 4, 1'b0);
    set_chan(1, 4000, 0, 8, 1'b1);
    fire();
    mix_if.ch_left = {$urandom, $urandom};
    tick();
    mix_if.ch_left[IN_W-1:0] = 16'h1234;
    tick(LAT - 1);
    check("mute_valid", mix_if.out_valid, 1);
    check("mute_left", mix_if.out_left, 24'h03E800);

    // Overrun: second strobe two cycles after the first
    clear_inputs();
    set_chan(0, 1000, -1000, 8, 1'b0);
    pulse_clear();
    check("overrun_clear", mix_if.overrun, 0);
    fire();
    tick();
    fire();
    lat = -1;
    nv  = 0;
    for (int i = 3; i <= LAT + 8; i++) begin
      tick();
      if (mix_if.out_valid) begin
        nv++;
        if (lat < 0) lat = i;
      end
    end
    check("overrun_latency", lat, LAT);
    check("overrun_valid_count", nv, 1);
    check("overrun_flag", mix_if.overrun, 1);

    // Reset mid-mix
    clear_inputs();
    set_chan(0, -1000, 1000, 8, 1'b0);
    fire();
    tick(3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_left", mix_if.out_left, 0);
    check("rst_mid_busy", mix_if.busy, 0);
    check("rst_mid_flags", {mix_if.out_valid, mix_if.clip_left, mix_if.overrun}, 0);
    tick(2);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (mix_if.out_valid) nv++;
    end
    check("rst_no_valid", nv, 0);
    set_chan(0, 1000, -1000, 8, 1'b0);
    run_mix(lat, nv);
    check("rst_after_latency", lat, LAT);
    check("rst_after_left", mix_if.out_left, 24'h01F400);

    // Randomized mixes with varied spacing, mid-mix input churn and clears
    for (int n = 0; n < 400; n++) begin
      int gap;
      for (int i = 0; i < NUM_CH; i++) begin
        int l, r;
        l = int'($urandom);
        r = int'($urandom);
        if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) != 0) ? 32'h7FFF : -32768;
        set_chan(i, l, r, int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end
      mix_if.master_vol = VOL_W'($urandom_range(0, 15));
      fire();
      gap = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LAT)) : int'($urandom_range(LAT, LAT + 4));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 3) == 0) mix_if.ch_left = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) mix_if.ch_right = {$urandom, $urandom};
        mix_if.clip_clear = ($urandom_range(0, 9) == 0);
        tick();
      end
      mix_if.clip_clear = 1'b0;
    end
    tick(LAT + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
